de_morgan_second_b: RTL and testbench
=====================================

# de_morgan_second_b

Two-input gate block implementing the right-hand side of De Morgan's second law: y = ~a | ~b. The combinational output y is the primary function and must hold without any clock activity. A clocked self-check path registers the result, recomputes the left-hand side ~(a & b) independently, and records mismatches and truth-table coverage for lab and regression use.

## Interface
Parameters:
- CNT_W, default 16: width of the saturating sample counter.

Ports:
- clk  input  1  sampling clock for the self-check path.
- rst_n  input  1  reset; asynchronous, active-low.
- a  input  1  operand A.
- b  input  1  operand B.
- y  output  1  combinational ~a | ~b.
- y_q  output  1  y registered on the rising edge of clk.
- lhs_q  output  1  ~(a & b), computed as a separate NAND expression, registered.
- mismatch  output  1  sticky flag: y_q != lhs_q was seen on any sample since reset.
- cov  output  4  sticky coverage bitmap. Bit index is {a,b}, so bit 0 = 00 and bit 3 = 11.
- samples  output  CNT_W  number of clock edges since reset, saturating at all-ones.

## Operation
- y is purely combinational from a and b. It does not depend on clk or rst_n, and has no X while a and b are known.
- Truth table for y: a=0,b=0 -> 1; a=0,b=1 -> 1; a=1,b=0 -> 1; a=1,b=1 -> 0.
- Self-check path, on each rising edge of clk while rst_n=1:
  - y_q <= ~a | ~b.
  - lhs_q <= ~(a & b). This must be a distinct expression from y and must not be derived from y.
  - cov[{a,b}] <= 1.
  - mismatch <= mismatch | ((~a | ~b) != ~(a & b)). This stays 0 for correct logic; it exists to catch synthesis or netlist errors.
  - samples <= samples + 1, unless samples is all-ones, in which case it holds.
- Reset (rst_n=0, asynchronous):
  - y_q=1 and lhs_q=1, which are the values for a=b=0.
  - mismatch=0, cov=4'b0000, samples=0.
  - y keeps following a and b during reset.
- Once a bit of cov or mismatch is set, it clears only by reset.

## Timing
- y: zero-cycle, combinational propagation only. It must settle within one gate delay of an input change, well under 100 ns.
- y_q, lhs_q, cov, mismatch and samples have 1-cycle latency. They reflect a and b as sampled at the previous rising edge of clk.
- Reset assertion takes effect immediately, with no clock needed.
- Reset deassertion is synchronized by the user. The first update happens on the first rising edge with rst_n=1.
- Reset asserted mid-operation clears all registered outputs at once. y is unaffected.
- An input change coincident with a clock edge is sampled as the pre-edge value, following the usual setup-time rules.
- samples saturation: at 2^CNT_W-1 it holds. The wrap to 0 is forbidden.

## Test plan
- Unclocked sweep. Hold clk=0, leave rst_n undriven or 1. Toggle b every 100 ns and a every 200 ns from a=b=0 for 1000 ns. Required y sequence per 100 ns slot: 1,1,1,0 repeating; y=0 exactly when a=b=1.
- Reset values. Drive rst_n=0 with no clock edge. Required: y_q=1, lhs_q=1, mismatch=0, cov=0000, samples=0, and y still tracks a and b.
- Clocked sweep. Release reset, then apply a,b = 00,01,10,11, one per clock. Required:
  - y_q and lhs_q read 1,1,1,0, each one cycle after its input.
  - cov=1111 after the 4th edge.
  - samples=4.
  - mismatch=0.
- Partial coverage. Apply only 11 for 3 cycles. Required: cov=1000, y_q=lhs_q=0, samples=3.
- Mid-run reset. During the clocked sweep, pulse rst_n low between clock edges. Required: all registered outputs return to their reset values immediately, and y is unchanged.
- Saturation, with CNT_W=3. Run 10 clocks. Required: samples reaches 7 and holds at 7.

Source files
------------

// File: rtl/de_morgan_second_b.sv
// rtl/de_morgan_second_b.sv - y = ~a | ~b with a registered self-check against ~(a & b)
module de_morgan_second_b #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    output logic             y,
    output logic             y_q,
    output logic             lhs_q,
    output logic             mismatch,
    output logic [3:0]       cov,
    output logic [CNT_W-1:0] samples
);

    logic       rhs;
    logic       lhs;
    logic [1:0] sel;

    // Both sides of the law are built as separate expressions so a netlist
    // error in one of them shows up as a mismatch rather than being shared.
    assign rhs = ~a | ~b;
    assign lhs = ~(a & b);
    assign sel = {a, b};
    assign y   = rhs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q      <= 1'b1;
            lhs_q    <= 1'b1;
            mismatch <= 1'b0;
            cov      <= 4'b0000;
            samples  <= '0;
        end else begin
            y_q      <= rhs;
            lhs_q    <= lhs;
            mismatch <= mismatch | (rhs != lhs);
            cov      <= cov | (4'b0001 << sel);
            if (samples != {CNT_W{1'b1}}) begin
                samples <= samples + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_de_morgan_second_b.sv
// tb/tb_de_morgan_second_b.sv - self-checking bench for de_morgan_second_b
module tb_de_morgan_second_b;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic        a;
    logic        b;
    logic        y, y_q, lhs_q, mismatch;
    logic [3:0]  cov;
    logic [15:0] samples;
    logic        s_y, s_y_q, s_lhs_q, s_mismatch;
    logic [3:0]  s_cov;
    logic [2:0]  s_samples;

    int tests = 0;
    int fails = 0;

    de_morgan_second_b dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .y(y), .y_q(y_q),
        .lhs_q(lhs_q), .mismatch(mismatch), .cov(cov), .samples(samples)
    );

    de_morgan_second_b #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .y(s_y), .y_q(s_y_q),
        .lhs_q(s_lhs_q), .mismatch(s_mismatch), .cov(s_cov), .samples(s_samples)
    );

    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : 1'b0;

    // Reference model: truth table of NAND indexed by {a,b}, plus plain counters.
    logic [3:0] tt;
    int         m_n;
    logic [3:0] m_cov;
    logic       m_yq;

    function automatic logic nand_ref(input logic x, input logic z);
        return !(x && z);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n   = 0;
        m_cov = 4'b0000;
        m_yq  = 1'b1;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".y_q"}, {31'd0, y_q}, {31'd0, m_yq});
        chk({tag, ".lhs_q"}, {31'd0, lhs_q}, {31'd0, m_yq});
        chk({tag, ".mismatch"}, {31'd0, mismatch}, 32'd0);
        chk({tag, ".cov"}, {28'd0, cov}, {28'd0, m_cov});
        chk({tag, ".samples"}, {16'd0, samples}, (m_n > 65535) ? 32'd65535 : m_n);
        chk({tag, ".sat_samples"}, {29'd0, s_samples}, (m_n > 7) ? 32'd7 : m_n);
        chk({tag, ".sat_cov"}, {28'd0, s_cov}, {28'd0, m_cov});
    endtask

    // Apply one input pair, clock it in, update model, sample 1 ns after the edge.
    task automatic step(input logic na, input logic nb);
        a = na;
        b = nb;
        @(posedge clk);
        m_n++;
        m_cov[{na, nb}] = 1'b1;
        m_yq = nand_ref(na, nb);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("rst_pulse");
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic a;
        logic b;
        logic exp_y;
        logic [3:0] exp_cov;
    } vec_t;

    vec_t vecs[4];

    initial begin
        tt     = 4'b0111;
        clk_en = 1'b0;
        rst_n  = 1'b1;
        a      = 1'b0;
        b      = 1'b0;
        model_reset();

        vecs[0] = '{a: 1'b0, b: 1'b0, exp_y: 1'b1, exp_cov: 4'b0001};
        vecs[1] = '{a: 1'b0, b: 1'b1, exp_y: 1'b1, exp_cov: 4'b0011};
        vecs[2] = '{a: 1'b1, b: 1'b0, exp_y: 1'b1, exp_cov: 4'b0111};
        vecs[3] = '{a: 1'b1, b: 1'b1, exp_y: 1'b0, exp_cov: 4'b1111};

        // Unclocked sweep: b toggles every 100 ns, a every 200 ns.
        for (int slot = 0; slot < 10; slot++) begin
            a = slot[1];
            b = slot[0];
            #50;
            chk("sweep_y", {31'd0, y}, {31'd0, tt[{a, b}]});
            chk("sweep_sat_y", {31'd0, s_y}, {31'd0, tt[{a, b}]});
            #50;
        end

        // Reset with no clock: registered outputs clear, y keeps tracking.
        rst_n = 1'b0;
        #1;
        check_regs("reset");
        for (int i = 0; i < 4; i++) begin
            a = i[1];
            b = i[0];
            #10;
            chk("reset_y_tracks", {31'd0, y}, {31'd0, tt[i]});
        end
        check_regs("reset_hold");

        // Clocked sweep from the table.
        a = 1'b0;
        b = 1'b0;
        rst_n = 1'b1;
        #10;
        clk_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(vecs[i].a, vecs[i].b);
            chk("tbl_y_q", {31'd0, y_q}, {31'd0, vecs[i].exp_y});
            chk("tbl_lhs_q", {31'd0, lhs_q}, {31'd0, vecs[i].exp_y});
            chk("tbl_cov", {28'd0, cov}, {28'd0, vecs[i].exp_cov});
            chk("tbl_samples", {16'd0, samples}, i + 1);
        end
        chk("tbl_mismatch", {31'd0, mismatch}, 32'd0);
        check_regs("tbl_end");

        // Partial coverage: only 11 for 3 cycles.
        pulse_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        chk("part_cov", {28'd0, cov}, 32'h8);
        chk("part_y_q", {31'd0, y_q}, 32'd0);
        chk("part_lhs_q", {31'd0, lhs_q}, 32'd0);
        chk("part_samples", {16'd0, samples}, 32'd3);

        // Mid-run reset between edges; y must be unaffected.
        pulse_reset();
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("mid_rst");
        chk("mid_rst_y", {31'd0, y}, 32'd0);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0);
        check_regs("mid_rst_after");

        // Saturation of the 3-bit counter over 10 clocks.
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            step(i[0], i[1]);
            chk("sat_samples", {29'd0, s_samples}, (i + 1 > 7) ? 32'd7 : i + 1);
        end
        chk("sat_main_samples", {16'd0, samples}, 32'd10);

        // Randomized run against the model, with occasional mid-cycle resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 24) == 0) pulse_reset();
            step(1'($urandom), 1'($urandom));
            chk("rnd_y", {31'd0, y}, {31'd0, nand_ref(a, b)});
            check_regs("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
